// File: rtl/mult_pkg.sv
// Shared definitions for the iterative arithmetic units: FSM state type and its encoding.
package mult_pkg;

  localparam int MULT_STATE_W = 2;

  localparam logic [MULT_STATE_W-1:0] ENC_IDLE = 2'b00;
  localparam logic [MULT_STATE_W-1:0] ENC_BUSY = 2'b01;
  localparam logic [MULT_STATE_W-1:0] ENC_DONE = 2'b10;

  typedef enum logic [MULT_STATE_W-1:0] {
    ST_IDLE = ENC_IDLE,
    ST_BUSY = ENC_BUSY,
    ST_DONE = ENC_DONE
  } mult_state_e;

  // Width of an iteration counter that must reach n inclusive without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/iter_multiplier_dp.sv
// Datapath of iter_multiplier: operand registers, shift-add accumulator and product register.
// MULT_SIGNED_EN adds magnitude conversion at load and sign fix-up of the final product.
module iter_multiplier_dp #(
  parameter int N_A = 8,
  parameter int N_B = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finish,
`ifdef MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  input  logic [N_A-1:0]       a,
  input  logic [N_B-1:0]       b,
  output logic [N_A+N_B-1:0]   product
);

  localparam int N_OUT = N_A + N_B;

  logic [N_OUT-1:0] a_q, a_d;
  logic [N_B:0]     b_q, b_d;
  logic [N_OUT-1:0] acc_q, acc_d;
  logic [N_OUT-1:0] product_q, product_d;

`ifdef MULT_SIGNED_EN
  logic           neg_q, neg_d;
  logic           a_neg, b_neg;
  logic [N_A:0]   a_ext, a_mag;
  logic [N_B:0]   b_ext, b_mag;

  // One extra bit keeps the magnitude of the most negative operand exact.
  always_comb begin
    a_neg = is_signed & a[N_A-1];
    b_neg = is_signed & b[N_B-1];
    a_ext = {a_neg, a};
    b_ext = {b_neg, b};
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end
`endif

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    if (load) begin
`ifdef MULT_SIGNED_EN
      a_d   = {{(N_B-1){1'b0}}, a_mag};
      b_d   = b_mag;
      neg_d = a_neg ^ b_neg;
`else
      a_d   = {{N_B{1'b0}}, a};
      b_d   = {1'b0, b};
`endif
      acc_d = '0;
    end else if (step) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end else if (finish) begin
`ifdef MULT_SIGNED_EN
      product_d = neg_q ? -acc_q : acc_q;
`else
      product_d = acc_q;
`endif
    end
  end

  // NOTE: only the visible product is reset; operand and accumulator registers are always
  // reloaded on accept, so resetting them would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
`ifdef MULT_SIGNED_EN
    neg_q <= neg_d;
`endif
  end

  assign product = product_q;

endmodule

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes; one operation in flight.
// Optional MULT_SIGNED_EN adds the is_signed port for two's-complement operation.
module iter_multiplier
  import mult_pkg::*;
#(
  parameter int N_A = 8,
  parameter int N_B = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_A-1:0]       A,
  input  logic [N_B-1:0]       B,
`ifdef MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_A+N_B-1:0]   OUTPUT
);

  localparam int N_OUT = N_A + N_B;
  localparam int CNT_W = cnt_width(N_B);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_B);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             load, step, finish;

  // N_B shift-add edges (cnt 0..N_B-1), then one edge to publish the (sign-fixed) product.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          load       = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          finish      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  iter_multiplier_dp #(
    .N_A (N_A),
    .N_B (N_B)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .finish    (finish),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .a         (A),
    .b         (B),
    .product   (OUTPUT)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed self-checking bench for iter_multiplier: default 8x8 instance plus a 16x4 instance.
// Signed vectors run when MULT_SIGNED_EN is defined.
module tb_iter_multiplier;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_a;
  logic [3:0]  w_b;
  logic        w_is_signed;
  logic        w_out_valid;
  logic [19:0] w_product;

  int checks;
  int errors;

  iter_multiplier u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUTPUT    (product)
  );

  iter_multiplier #(
    .N_A (16),
    .N_B (4)
  ) u_dut_w (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .A         (w_a),
    .B         (w_b),
`ifdef MULT_SIGNED_EN
    .is_signed (w_is_signed),
`endif
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .OUTPUT    (w_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble A/B while busy, and check latency and product.
  task automatic do_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                       input logic sgn, input logic [15:0] exp);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a         = op_a;
    b         = op_b;
    is_signed = sgn;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    a         = ~op_a;
    b         = ~op_b;
    is_signed = ~sgn;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_product"}, 64'(product), 64'(exp));
    tick();
    check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    is_signed   = 1'b0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_is_signed = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_output", 64'(product), 64'd0);
    check("rst_w_in_ready", 64'(w_in_ready), 64'd1);
    check("rst_w_output", 64'(w_product), 64'd0);
    reset = 1'b1;
    tick();

    do_op("mul_02_0a", 8'h02, 8'h0A, 1'b0, 16'h0014);
    do_op("mul_12_0a", 8'h12, 8'h0A, 1'b0, 16'h00B4);
    do_op("mul_07_0f", 8'h07, 8'h0F, 1'b0, 16'h0069);
    do_op("mul_82_ca", 8'h82, 8'hCA, 1'b0, 16'h6694);
    do_op("mul_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    do_op("mul_00_ab", 8'h00, 8'hAB, 1'b0, 16'h0000);

    // Backpressure: product held while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    a         = 8'h12;
    b         = 8'h0A;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd9);
    a        = 8'h55;
    b        = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_output", 64'(product), 64'h00B4);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_output", 64'(product), 64'h00B4);

    // Reset sampled on the third BUSY edge discards the op.
    a        = 8'h55;
    b        = 8'h33;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_output", 64'(product), 64'd0);
    do_op("mul_03_05", 8'h03, 8'h05, 1'b0, 16'h000F);

    // Wide instance, N_A=16, N_B=4.
    w_a        = 16'hFFFF;
    w_b        = 4'hF;
    w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    w_a        = 16'h1234;
    w_b        = 4'h1;
    lat = 0;
    while (!w_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("wide_latency", 64'(lat), 64'd5);
    check("wide_product", 64'(w_product), 64'hEFFF1);

`ifdef MULT_SIGNED_EN
    do_op("smul_fe_03", 8'hFE, 8'h03, 1'b1, 16'hFFFA);
    do_op("smul_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    do_op("umul_fe_03", 8'hFE, 8'h03, 1'b0, 16'h02FA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
